load_store_unit: RTL and testbench
==================================

# load_store_unit

Load/store unit between the execute stage and the word-organised data memory of the RISC-V core. Accepts one RV32I memory request at a time (LB/LH/LW/LBU/LHU/SB/SH/SW) with a byte address. Translates it into word-wide data-memory accesses. Sub-word stores are done as read-modify-write, because the data memory has only a whole-word write enable. Loads return lane-extracted, sign- or zero-extended data; misaligned or illegal requests return an error response and never touch memory.

## Interface
- ADDR_W, 5, data-memory word-address width (2^ADDR_W words of 32 bits)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; request accepted on edge where req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (loads 000/001/010/100/101; stores 000/001/010)
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low byte/half used for SB/SH)
- resp_valid  out  1  one-cycle response pulse; no backpressure
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  misaligned address or illegal funct3
- dm_addr  out  ADDR_W  word address to data memory
- dm_wd  out  32  write data to data memory
- dm_we  out  1  data-memory write enable
- dm_rd  in  32  data-memory read data; valid the cycle after dm_addr is presented with dm_we=0

## Operation
- FSM states: IDLE, RD, MRG, WR, RESP.
- req_ready = (state==IDLE) & ~rst. Only one request is outstanding.
- req_valid while busy is ignored and not queued.
- On accept, latch we, funct3, addr, wdata. Word address = addr[ADDR_W+1:2]; upper address bits are ignored, so the address wraps.
- Error check at accept:
  - illegal funct3: load 011/110/111; store anything but 000/001/010
  - misalignment: LW/SW addr[1:0]≠0; LH/LHU/SH addr[0]≠0
  - On error: IDLE→RESP with resp_err=1, resp_rdata=0; dm_we never asserted.
- Transitions:
  - SW: IDLE→WR→RESP. In WR: dm_we=1, dm_wd=wdata.
  - Loads: IDLE→RD→MRG→RESP.
    - RD drives dm_addr.
    - MRG captures the extracted dm_rd into resp_rdata.
  - SB/SH: IDLE→RD→MRG→RESP. In MRG: dm_we=1, dm_wd = dm_rd with the lane replaced.
- Lane rules:
  - SB replaces byte addr[1:0] with wdata[7:0].
  - SH replaces half addr[1] with wdata[15:0].
  - LB/LH sign-extend the selected lane; LBU/LHU zero-extend; LW returns the word.
- RESP: resp_valid=1 for exactly one cycle, then →IDLE.
  - resp_rdata and resp_err hold until the next response is loaded.
- dm_addr is driven from the latched address in all non-IDLE states. dm_we=0 in every state except WR and store-MRG.
- dm_we is gated by ~rst.

## Timing
- Accept edge = cycle 0.
- Response timing:
  - Error: resp_valid in cycle 1.
  - SW: dm_we in cycle 1, resp_valid in cycle 2.
  - Loads: dm_rd sampled in cycle 2, resp_valid in cycle 3.
  - SB/SH: read in cycle 1, merged write (dm_we=1) in cycle 2, resp_valid in cycle 3.
- Next request can be accepted in the cycle after RESP. Peak throughput is one SW per 3 cycles.
- Reset values: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, dm_we=0, dm_addr=0, dm_wd=0; req_ready=0 while rst=1.
- rst mid-operation: the request is abandoned and no resp_valid is produced.
  - If rst is high during WR or store-MRG, dm_we=0 that cycle and memory is unchanged.
  - In the first cycle after rst deasserts, req_ready=1.
- req_valid coincident with rst is not accepted.

## Test plan
- SW 0xDEADBEEF @0x08, then LW @0x08:
  - SW: dm_we=1 one cycle with dm_addr=2 and dm_wd=0xDEADBEEF; resp_valid in cycle 2, rdata=0, err=0.
  - LW: resp_rdata=0xDEADBEEF in cycle 3.
- Word 2 = 0x11223344, SB 0xA5 @0x0B:
  - Word becomes 0xA5223344.
  - LB @0x0B → 0xFFFFFFA5; LBU @0x0B → 0x000000A5; LB @0x08 → 0x00000044.
- Word 1 = 0, SH 0x8001 @0x06:
  - Word becomes 0x80010000.
  - LH @0x06 → 0xFFFF8001; LHU @0x06 → 0x00008001.
- Error cases: LW @0x05, SH @0x03, load funct3=011, store funct3=100.
  - Each gives resp_err=1 and resp_rdata=0 in cycle 1, with dm_we never high.
  - req_valid held high while busy is not double-accepted.
- rst pulsed in the MRG cycle of SB @0x00 over 0x11223344:
  - dm_we=0, word still 0x11223344, no resp_valid.
  - req_ready=1 in the cycle after rst deasserts.
- With ADDR_W=5, SW 0xCAFEF00D @0x80 → dm_addr=0. LW @0x00 then returns 0xCAFEF00D.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
// The unit itself connects through the slave view; the execute/memory side uses master.
interface load_store_unit_if #(
    parameter int ADDR_W = 5
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wd;
    logic              dm_we;
    logic [31:0]       dm_rd;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, dm_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, dm_addr, dm_wd, dm_we
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, dm_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, dm_addr, dm_wd, dm_we
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit over a word-wide data memory; sub-word stores use
// read-modify-write because the memory has only a whole-word write enable.
module load_store_unit #(
    parameter int ADDR_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD, MRG, WR, RESP} state_t;

    state_t            state_reg, state_next;
    logic              we_reg;
    logic [2:0]        funct3_reg;
    logic [ADDR_W-1:0] waddr_reg;
    logic [1:0]        lane_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       rdata_reg;
    logic              err_reg;

    logic              accept;
    logic              illegal;
    logic              misaligned;
    logic              req_err;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_data;
    logic [31:0]       merge_word;
    logic              unused_addr_bits;

    // Address bits above the memory's reach are deliberately dropped (wrap-around).
    assign unused_addr_bits = ^bus.req_addr[31:ADDR_W+2];

    assign accept = bus.req_valid & bus.req_ready;

    always_comb begin
        illegal = (bus.req_funct3[1:0] == 2'b11) |
                  (bus.req_we ? bus.req_funct3[2] : (bus.req_funct3 == 3'b110));
        case (bus.req_funct3[1:0])
            2'b10:   misaligned = (bus.req_addr[1:0] != 2'b00);
            2'b01:   misaligned = bus.req_addr[0];
            default: misaligned = 1'b0;
        endcase
        req_err = illegal | misaligned;
    end

    assign byte_sel = bus.dm_rd[8*lane_reg +: 8];
    assign half_sel = lane_reg[1] ? bus.dm_rd[31:16] : bus.dm_rd[15:0];

    always_comb begin
        case (funct3_reg)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = bus.dm_rd;
        endcase
    end

    // Per-byte merge: keep the memory byte unless this lane is the store target.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            logic byte_hit;
            logic half_hit;
            assign byte_hit = (funct3_reg[1:0] == 2'b00) && (lane_reg == 2'(gi));
            assign half_hit = (funct3_reg[1:0] == 2'b01) && (lane_reg[1] == 1'(gi / 2));
            assign merge_word[8*gi +: 8] = byte_hit ? wdata_reg[7:0] :
                                           half_hit ? wdata_reg[8*(gi % 2) +: 8] :
                                                      bus.dm_rd[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            we_reg     <= 1'b0;
            funct3_reg <= 3'd0;
            waddr_reg  <= '0;
            lane_reg   <= 2'd0;
            wdata_reg  <= 32'd0;
            rdata_reg  <= 32'd0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                we_reg     <= bus.req_we;
                funct3_reg <= bus.req_funct3;
                waddr_reg  <= bus.req_addr[ADDR_W+1:2];
                lane_reg   <= bus.req_addr[1:0];
                wdata_reg  <= bus.req_wdata;
            end
            case (state_reg)
                IDLE: if (accept && req_err) begin
                    rdata_reg <= 32'd0;
                    err_reg   <= 1'b1;
                end
                WR: begin
                    rdata_reg <= 32'd0;
                    err_reg   <= 1'b0;
                end
                MRG: begin
                    rdata_reg <= we_reg ? 32'd0 : load_data;
                    err_reg   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next     = state_reg;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.dm_we      = 1'b0;
        bus.dm_wd      = 32'd0;
        bus.dm_addr    = waddr_reg;
        bus.resp_rdata = rdata_reg;
        bus.resp_err   = err_reg;
        case (state_reg)
            IDLE: begin
                bus.req_ready = ~rst;
                if (accept) begin
                    if (req_err)
                        state_next = RESP;
                    else if (bus.req_we && (bus.req_funct3 == 3'b010))
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD:  state_next = MRG;
            MRG: begin
                state_next = RESP;
                if (we_reg) begin
                    bus.dm_we = ~rst;
                    bus.dm_wd = merge_word;
                end
            end
            WR: begin
                state_next = RESP;
                bus.dm_we  = ~rst;
                bus.dm_wd  = wdata_reg;
            end
            RESP: begin
                state_next     = IDLE;
                bus.resp_valid = ~rst;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-read word memory model.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic        pre_en   = 1'b0;
    logic [4:0]  pre_addr = 5'd0;
    logic [31:0] pre_data = 32'd0;
    logic [31:0] mem [32];

    load_store_unit_if #(.ADDR_W(5)) bus ();

    load_store_unit #(.ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_en)
            mem[pre_addr] <= pre_data;
        else if (bus.dm_we)
            mem[bus.dm_addr] <= bus.dm_wd;
        bus.dm_rd <= mem[bus.dm_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_wcyc, input logic [31:0] exp_wa, input logic [31:0] exp_wd,
                          input logic hold);
        int          got_lat  = 0;
        int          resp_cnt = 0;
        int          we_cnt   = 0;
        int          wcyc     = 0;
        logic [31:0] wa = 32'd0;
        logic [31:0] wd = 32'd0;
        logic [31:0] rd = 32'd0;
        logic        er = 1'b0;
        @(negedge clk);
        chk({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        #1;
        if (!hold) bus.req_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (bus.dm_we) begin
                we_cnt++;
                wcyc = c;
                wa   = 32'(bus.dm_addr);
                wd   = bus.dm_wd;
            end
            if (bus.resp_valid) begin
                resp_cnt++;
                got_lat = c;
                rd = bus.resp_rdata;
                er = bus.resp_err;
                bus.req_valid = 1'b0;
            end
        end
        bus.req_valid = 1'b0;
        $display("req %s we=%0d f3=%0d addr=%h lat=%0d rdata=%h err=%0d writes=%0d",
                 tag, we, f3, addr, got_lat, rd, er, we_cnt);
        chk({tag, ".lat"},   32'(got_lat),  32'(exp_lat));
        chk({tag, ".rdata"}, rd,            exp_rdata);
        chk({tag, ".err"},   32'(er),       32'(exp_err));
        chk({tag, ".nresp"}, 32'(resp_cnt), 32'd1);
        chk({tag, ".nwe"},   32'(we_cnt),   (exp_wcyc != 0) ? 32'd1 : 32'd0);
        if (exp_wcyc != 0) begin
            chk({tag, ".wcyc"}, 32'(wcyc), 32'(exp_wcyc));
            chk({tag, ".wa"},   wa,        exp_wa);
            chk({tag, ".wd"},   wd,        exp_wd);
        end
    endtask

    initial begin
        int nresp;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.ready",  32'(bus.req_ready),  32'd0);
        chk("rst.valid",  32'(bus.resp_valid), 32'd0);
        chk("rst.dm_we",  32'(bus.dm_we),      32'd0);
        chk("rst.rdata",  bus.resp_rdata,      32'd0);
        chk("rst.err",    32'(bus.resp_err),   32'd0);
        chk("rst.dmaddr", 32'(bus.dm_addr),    32'd0);
        chk("rst.dmwd",   bus.dm_wd,           32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        do_req("sw08",  1, 3'b010, 32'h08, 32'hDEADBEEF, 2, 32'h0, 0, 1, 32'd2, 32'hDEADBEEF, 0);
        chk("mem2.sw", mem[2], 32'hDEADBEEF);
        do_req("lw08",  0, 3'b010, 32'h08, 32'h0, 3, 32'hDEADBEEF, 0, 0, 32'd0, 32'd0, 0);

        preload(5'd2, 32'h11223344);
        do_req("sb0b",  1, 3'b000, 32'h0B, 32'h123456A5, 3, 32'h0, 0, 2, 32'd2, 32'hA5223344, 0);
        chk("mem2.sb", mem[2], 32'hA5223344);
        do_req("lb0b",  0, 3'b000, 32'h0B, 32'h0, 3, 32'hFFFFFFA5, 0, 0, 32'd0, 32'd0, 0);
        do_req("lbu0b", 0, 3'b100, 32'h0B, 32'h0, 3, 32'h000000A5, 0, 0, 32'd0, 32'd0, 0);
        do_req("lb08",  0, 3'b000, 32'h08, 32'h0, 3, 32'h00000044, 0, 0, 32'd0, 32'd0, 0);

        preload(5'd1, 32'h0);
        do_req("sh06",  1, 3'b001, 32'h06, 32'hBEEF8001, 3, 32'h0, 0, 2, 32'd1, 32'h80010000, 0);
        chk("mem1.sh", mem[1], 32'h80010000);
        do_req("lh06",  0, 3'b001, 32'h06, 32'h0, 3, 32'hFFFF8001, 0, 0, 32'd0, 32'd0, 0);
        do_req("lhu06", 0, 3'b101, 32'h06, 32'h0, 3, 32'h00008001, 0, 0, 32'd0, 32'd0, 0);

        do_req("lw05",  0, 3'b010, 32'h05, 32'h0, 1, 32'h0, 1, 0, 32'd0, 32'd0, 0);
        do_req("sh03",  1, 3'b001, 32'h03, 32'hFFFF, 1, 32'h0, 1, 0, 32'd0, 32'd0, 1);
        do_req("ld011", 0, 3'b011, 32'h00, 32'h0, 1, 32'h0, 1, 0, 32'd0, 32'd0, 0);
        do_req("st100", 1, 3'b100, 32'h00, 32'h1, 1, 32'h0, 1, 0, 32'd0, 32'd0, 1);

        // Reset pulse lands on the merge-write cycle of an SB.
        preload(5'd0, 32'h11223344);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h00;
        bus.req_wdata  = 32'h000000EE;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rstmrg.dm_we", 32'(bus.dm_we),      32'd0);
        chk("rstmrg.valid", 32'(bus.resp_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmrg.ready", 32'(bus.req_ready), 32'd1);
        nresp = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.resp_valid) nresp++;
            @(negedge clk);
        end
        $display("req rstmrg sb addr=00000000 responses=%0d mem0=%h", nresp, mem[0]);
        chk("rstmrg.nresp", 32'(nresp), 32'd0);
        chk("rstmrg.mem0",  mem[0],     32'h11223344);

        do_req("sw80",  1, 3'b010, 32'h80, 32'hCAFEF00D, 2, 32'h0, 0, 1, 32'd0, 32'hCAFEF00D, 0);
        do_req("lw00",  0, 3'b010, 32'h00, 32'h0, 3, 32'hCAFEF00D, 0, 0, 32'd0, 32'd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
